// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared types and sizing for the mesh NoC and its network interface.
//   - Mesh geometry and address widths
//   - Virtual channel count and flit payload width
//   - flit_label_t / flit_t:  flit on the router-to-router link
//   - head_data_t:            layout of the payload field in a head flit
//   - ni_state_t:             network-interface injection FSM states
//   - make_head_data():       packs destination/source into a head payload
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int MESH_SIZE_X      = 4;
    localparam int MESH_SIZE_Y      = 4;
    localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
    localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
    localparam int VC_NUM           = 4;
    localparam int VC_SIZE          = $clog2(VC_NUM);
    localparam int FLIT_DATA_SIZE   = 16;

    // Unused upper bits of the head payload once dest+source are packed.
    localparam int HEAD_PAD_SIZE = FLIT_DATA_SIZE - 2*DEST_ADDR_SIZE_X - 2*DEST_ADDR_SIZE_Y;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t                flit_label;
        logic [VC_SIZE-1:0]         vc_id;
        logic [FLIT_DATA_SIZE-1:0]  data;
    } flit_t;

    // Head payload, MSB first: pad | x_dest | y_dest | x_src | y_src
    typedef struct packed {
        logic [HEAD_PAD_SIZE-1:0]    pad;
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [DEST_ADDR_SIZE_X-1:0] x_src;
        logic [DEST_ADDR_SIZE_Y-1:0] y_src;
    } head_data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ALLOC = 2'b01,
        SEND  = 2'b10
    } ni_state_t;

    function automatic logic [FLIT_DATA_SIZE-1:0] make_head_data(
        input logic [DEST_ADDR_SIZE_X-1:0] x_dest,
        input logic [DEST_ADDR_SIZE_Y-1:0] y_dest,
        input logic [DEST_ADDR_SIZE_X-1:0] x_src,
        input logic [DEST_ADDR_SIZE_Y-1:0] y_src
    );
        head_data_t h;
        h        = '0;
        h.x_dest = x_dest;
        h.y_dest = y_dest;
        h.x_src  = x_src;
        h.y_src  = y_src;
        return h;
    endfunction

endpackage

// File: rtl/router2router_if.sv
// -----------------------------------------------------------------------------
// router2router
// One direction of a router-to-router link.
//   data           : flit being transferred
//   is_valid       : data carries a flit this cycle (one-cycle pulse per flit)
//   is_on_off      : per-VC credit-free flow control from the receiver
//                    (1 = sender may put a flit on that VC)
//   is_allocatable : per-VC "free to be claimed by a new packet" from receiver
// Modports:
//   upstream   : the sender   (drives data/is_valid, reads VC status)
//   downstream : the receiver (reads data/is_valid, drives VC status)
// -----------------------------------------------------------------------------
interface router2router;
    import noc_pkg::*;

    flit_t              data;
    logic               is_valid;
    logic [VC_NUM-1:0]  is_on_off;
    logic [VC_NUM-1:0]  is_allocatable;

    modport upstream (
        output data,
        output is_valid,
        input  is_on_off,
        input  is_allocatable
    );

    modport downstream (
        input  data,
        input  is_valid,
        output is_on_off,
        output is_allocatable
    );

endinterface

// File: rtl/network_interface_ejector.sv
// -----------------------------------------------------------------------------
// ni_ejector
// Ejection datapath of the network interface. Every flit arriving from the
// router LOCAL output is registered onto the rx_* stream one cycle later.
// Tracks which VCs currently carry an open packet, counts completed packets,
// and flags framing errors in the same cycle the offending flit appears.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_flit_valid    : incoming flit valid
//   i_flit          : incoming flit
//   o_rx_valid      : registered flit valid
//   o_rx_head       : flit is HEAD or HEADTAIL
//   o_rx_last       : flit is TAIL or HEADTAIL
//   o_rx_data       : flit payload
//   o_rx_pkt_cnt    : completed packets, wraps modulo 2^16
//   o_error         : framing error on the flit currently on rx_*
// -----------------------------------------------------------------------------
module ni_ejector
    import noc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flit_valid,
    input  flit_t                     i_flit,
    output logic                      o_rx_valid,
    output logic                      o_rx_head,
    output logic                      o_rx_last,
    output logic [FLIT_DATA_SIZE-1:0] o_rx_data,
    output logic [15:0]               o_rx_pkt_cnt,
    output logic                      o_error
);

    logic [VC_NUM-1:0]         r_open;
    logic                      r_rx_valid;
    logic                      r_rx_head;
    logic                      r_rx_last;
    logic [FLIT_DATA_SIZE-1:0] r_rx_data;
    logic [15:0]               r_pkt_cnt;
    logic                      r_error;

    logic                      w_is_head;
    logic                      w_is_last;
    logic                      w_vc_open;
    logic                      w_proto_err;
    logic [VC_NUM-1:0]         w_open_next;

    always_comb begin
        w_is_head   = (i_flit.flit_label == HEAD) || (i_flit.flit_label == HEADTAIL);
        w_is_last   = (i_flit.flit_label == TAIL) || (i_flit.flit_label == HEADTAIL);
        w_vc_open   = r_open[i_flit.vc_id];
        // A head must start on a closed VC; body/tail must continue an open one.
        w_proto_err = i_flit_valid && (w_is_head ? w_vc_open : !w_vc_open);

        w_open_next = r_open;
        if (i_flit_valid) begin
            if (i_flit.flit_label == HEAD) begin
                w_open_next[i_flit.vc_id] = 1'b1;
            end else if (i_flit.flit_label == TAIL) begin
                w_open_next[i_flit.vc_id] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_open     <= '0;
            r_rx_valid <= 1'b0;
            r_rx_head  <= 1'b0;
            r_rx_last  <= 1'b0;
            r_rx_data  <= '0;
            r_pkt_cnt  <= '0;
            r_error    <= 1'b0;
        end else begin
            r_open     <= w_open_next;
            r_rx_valid <= i_flit_valid;
            r_rx_head  <= i_flit_valid && w_is_head;
            r_rx_last  <= i_flit_valid && w_is_last;
            r_error    <= w_proto_err;
            if (i_flit_valid) begin
                r_rx_data <= i_flit.data;
            end
            if (i_flit_valid && w_is_last) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end

    assign o_rx_valid   = r_rx_valid;
    assign o_rx_head    = r_rx_head;
    assign o_rx_last    = r_rx_last;
    assign o_rx_data    = r_rx_data;
    assign o_rx_pkt_cnt = r_pkt_cnt;
    assign o_error      = r_error;

endmodule

// File: rtl/network_interface.sv
// -----------------------------------------------------------------------------
// network_interface
// Mesh-node endpoint on the router LOCAL port.
// Injection: accepts a packet descriptor, claims the lowest free downstream VC
// that is also switched on, emits a head flit, then turns payload words into
// body/tail flits while honouring per-VC on/off flow control.
// Ejection: handled by ni_ejector; always accepts.
//
// Handshakes: a descriptor (pkt_*) or payload word (pld_*) transfers on any
// rising clk edge where its valid and ready are both high. valid may rise
// independently of ready; once raised, the data must stay stable until the
// transfer. ready never depends on valid.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   pkt_valid_i/ready : descriptor handshake
//   pkt_x/y_dest_i    : destination coordinates
//   pkt_len_i         : packet length in flits, head included (1..MAX_PKT_LEN)
//   pld_valid_i/ready : payload handshake, pld_data_i body/tail payload
//   router_if_up      : flits to the router LOCAL input
//   router_if_down    : flits from the router LOCAL output
//   rx_*              : ejected flit stream and packet counter
//   error_o           : one-cycle pulse on any protocol error
//   dbg_state_o       : injection FSM state
// -----------------------------------------------------------------------------
module network_interface
    import noc_pkg::*;
#(
    parameter int MAX_PKT_LEN = 8,
    parameter int X_CURRENT   = MESH_SIZE_X / 2,
    parameter int Y_CURRENT   = MESH_SIZE_Y / 2
)(
    input  logic                               clk,
    input  logic                               rst,

    input  logic                               pkt_valid_i,
    output logic                               pkt_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0]        pkt_x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]        pkt_y_dest_i,
    input  logic [$clog2(MAX_PKT_LEN+1)-1:0]   pkt_len_i,

    input  logic                               pld_valid_i,
    output logic                               pld_ready_o,
    input  logic [FLIT_DATA_SIZE-1:0]          pld_data_i,

    router2router.upstream                     router_if_up,
    router2router.downstream                   router_if_down,

    output logic                               rx_valid_o,
    output logic                               rx_head_o,
    output logic                               rx_last_o,
    output logic [FLIT_DATA_SIZE-1:0]          rx_data_o,
    output logic [15:0]                        rx_pkt_cnt_o,
    output logic                               error_o,

    output ni_state_t                          dbg_state_o
);

    localparam int              LEN_W   = $clog2(MAX_PKT_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    // ---------------------------------------------------------------- state
    ni_state_t                  r_state;
    ni_state_t                  w_next_state;

    logic [DEST_ADDR_SIZE_X-1:0] r_x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] r_y_dest;
    logic [LEN_W-1:0]            r_len;
    logic [LEN_W-1:0]            r_remaining;
    logic [VC_SIZE-1:0]          r_vc;
    flit_t                       r_flit;
    logic                        r_flit_valid;
    logic                        r_inj_error;

    // ------------------------------------------------------------- decisions
    logic [VC_NUM-1:0]           w_vc_req;
    logic                        w_vc_found;
    logic [VC_SIZE-1:0]          w_vc_sel;
    logic                        w_desc_take;
    logic                        w_inj_error;
    logic                        w_head_emit;
    logic                        w_pld_fire;
    logic                        w_emit;
    flit_t                       w_flit;

    logic                        w_ej_error;

    // Lowest-numbered VC that is both free and switched on.
    always_comb begin
        w_vc_req   = router_if_up.is_allocatable & router_if_up.is_on_off;
        w_vc_found = 1'b0;
        w_vc_sel   = '0;
        for (int v = VC_NUM - 1; v >= 0; v--) begin
            if (w_vc_req[v]) begin
                w_vc_found = 1'b1;
                w_vc_sel   = VC_SIZE'(v);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        pkt_ready_o  = 1'b0;
        pld_ready_o  = 1'b0;
        w_desc_take  = 1'b0;
        w_inj_error  = 1'b0;
        w_head_emit  = 1'b0;
        w_pld_fire   = 1'b0;
        w_emit       = 1'b0;
        w_flit       = '0;

        case (r_state)
            IDLE: begin
                pkt_ready_o = 1'b1;
                if (pkt_valid_i) begin
                    if ((pkt_len_i == '0) || (pkt_len_i > MAX_LEN)) begin
                        // Illegal length: report and drop the descriptor.
                        w_inj_error = 1'b1;
                    end else begin
                        w_desc_take  = 1'b1;
                        w_next_state = ALLOC;
                    end
                end
            end

            ALLOC: begin
                if (w_vc_found) begin
                    w_head_emit       = 1'b1;
                    w_emit            = 1'b1;
                    w_flit.flit_label = (r_len == ONE) ? HEADTAIL : HEAD;
                    w_flit.vc_id      = w_vc_sel;
                    w_flit.data       = make_head_data(r_x_dest, r_y_dest,
                                                       DEST_ADDR_SIZE_X'(X_CURRENT),
                                                       DEST_ADDR_SIZE_Y'(Y_CURRENT));
                    w_next_state      = (r_len == ONE) ? IDLE : SEND;
                end
            end

            SEND: begin
                pld_ready_o = router_if_up.is_on_off[r_vc];
                if (pld_valid_i && pld_ready_o) begin
                    w_pld_fire        = 1'b1;
                    w_emit            = 1'b1;
                    w_flit.flit_label = (r_remaining == ONE) ? TAIL : BODY;
                    w_flit.vc_id      = r_vc;
                    w_flit.data       = pld_data_i;
                    if (r_remaining == ONE) begin
                        w_next_state = IDLE;
                    end
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_dest     <= '0;
            r_y_dest     <= '0;
            r_len        <= '0;
            r_remaining  <= '0;
            r_vc         <= '0;
            r_flit       <= '0;
            r_flit_valid <= 1'b0;
            r_inj_error  <= 1'b0;
        end else begin
            r_flit_valid <= w_emit;
            r_inj_error  <= w_inj_error;
            if (w_emit) begin
                r_flit <= w_flit;
            end
            if (w_desc_take) begin
                r_x_dest <= pkt_x_dest_i;
                r_y_dest <= pkt_y_dest_i;
                r_len    <= pkt_len_i;
            end
            if (w_head_emit) begin
                r_vc        <= w_vc_sel;
                r_remaining <= r_len - ONE;
            end else if (w_pld_fire) begin
                r_remaining <= r_remaining - ONE;
            end
        end
    end

    assign router_if_up.data     = r_flit;
    assign router_if_up.is_valid = r_flit_valid;

    // ------------------------------------------------------------- ejection
    // The endpoint is a pure sink: every VC is always free and switched on.
    assign router_if_down.is_on_off      = '1;
    assign router_if_down.is_allocatable = '1;

    ni_ejector u_ejector (
        .clk          (clk),
        .rst          (rst),
        .i_flit_valid (router_if_down.is_valid),
        .i_flit       (router_if_down.data),
        .o_rx_valid   (rx_valid_o),
        .o_rx_head    (rx_head_o),
        .o_rx_last    (rx_last_o),
        .o_rx_data    (rx_data_o),
        .o_rx_pkt_cnt (rx_pkt_cnt_o),
        .o_error      (w_ej_error)
    );

    // Both sources are registered, so coincident errors merge into one pulse.
    assign error_o     = r_inj_error | w_ej_error;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_network_interface.sv
module tb_network_interface;
    import noc_pkg::*;

    localparam int MAX_PKT_LEN = 8;
    localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1);

    // ------------------------------------------------------ clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                        pkt_valid_i;
    logic                        pkt_ready_o;
    logic [DEST_ADDR_SIZE_X-1:0] pkt_x_dest_i;
    logic [DEST_ADDR_SIZE_Y-1:0] pkt_y_dest_i;
    logic [LEN_W-1:0]            pkt_len_i;
    logic                        pld_valid_i;
    logic                        pld_ready_o;
    logic [FLIT_DATA_SIZE-1:0]   pld_data_i;
    logic                        rx_valid_o;
    logic                        rx_head_o;
    logic                        rx_last_o;
    logic [FLIT_DATA_SIZE-1:0]   rx_data_o;
    logic [15:0]                 rx_pkt_cnt_o;
    logic                        error_o;
    ni_state_t                   dbg_state_o;

    router2router up_if ();
    router2router down_if ();

    network_interface #(.MAX_PKT_LEN(MAX_PKT_LEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .pkt_valid_i    (pkt_valid_i),
        .pkt_ready_o    (pkt_ready_o),
        .pkt_x_dest_i   (pkt_x_dest_i),
        .pkt_y_dest_i   (pkt_y_dest_i),
        .pkt_len_i      (pkt_len_i),
        .pld_valid_i    (pld_valid_i),
        .pld_ready_o    (pld_ready_o),
        .pld_data_i     (pld_data_i),
        .router_if_up   (up_if),
        .router_if_down (down_if),
        .rx_valid_o     (rx_valid_o),
        .rx_head_o      (rx_head_o),
        .rx_last_o      (rx_last_o),
        .rx_data_o      (rx_data_o),
        .rx_pkt_cnt_o   (rx_pkt_cnt_o),
        .error_o        (error_o),
        .dbg_state_o    (dbg_state_o)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input logic [1:0] x, input logic [1:0] y, input logic [LEN_W-1:0] len);
        pkt_x_dest_i = x;
        pkt_y_dest_i = y;
        pkt_len_i    = len;
        pkt_valid_i  = 1'b1;
        tick();
        pkt_valid_i  = 1'b0;
        #1;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_vectors++; if (up_if.is_valid !== 1'b0) begin n_miscompares++; $display("FAIL reset_is_valid got %b exp 0", up_if.is_valid); end
        n_vectors++; if (up_if.data !== '0) begin n_miscompares++; $display("FAIL reset_up_data got %h exp 0", up_if.data); end
        n_vectors++; if ({rx_valid_o, rx_head_o, rx_last_o, error_o} !== 4'b0000) begin n_miscompares++; $display("FAIL reset_rx_flags got %b exp 0000", {rx_valid_o, rx_head_o, rx_last_o, error_o}); end
        n_vectors++; if (rx_data_o !== 16'h0000) begin n_miscompares++; $display("FAIL reset_rx_data got %h exp 0000", rx_data_o); end
        n_vectors++; if (rx_pkt_cnt_o !== 16'h0000) begin n_miscompares++; $display("FAIL reset_cnt got %h exp 0000", rx_pkt_cnt_o); end
        n_vectors++; if (dbg_state_o !== IDLE) begin n_miscompares++; $display("FAIL reset_state got %0d exp IDLE", dbg_state_o); end
        n_vectors++; if (pkt_ready_o !== 1'b1) begin n_miscompares++; $display("FAIL reset_pkt_ready got %b exp 1", pkt_ready_o); end
        n_vectors++; if ({down_if.is_on_off, down_if.is_allocatable} !== 8'hFF) begin n_miscompares++; $display("FAIL down_vc_status got %h exp ff", {down_if.is_on_off, down_if.is_allocatable}); end
    endtask

    // len=1, dest(1,0): single HEADTAIL on VC0, head payload 0x004A.
    task automatic test_single_flit();
        up_if.is_allocatable = 4'b1111;
        up_if.is_on_off      = 4'b1111;
        #1;
        n_vectors++; if (pkt_ready_o !== 1'b1) begin n_miscompares++; $display("FAIL t1_ready_idle got %b exp 1", pkt_ready_o); end
        send_desc(2'd1, 2'd0, 4'd1);
        n_vectors++; if (pkt_ready_o !== 1'b0) begin n_miscompares++; $display("FAIL t1_ready_alloc got %b exp 0", pkt_ready_o); end
        n_vectors++; if (up_if.is_valid !== 1'b0) begin n_miscompares++; $display("FAIL t1_early_valid got %b exp 0", up_if.is_valid); end
        tick();
        n_vectors++; if (up_if.is_valid !== 1'b1) begin n_miscompares++; $display("FAIL t1_valid got %b exp 1", up_if.is_valid); end
        n_vectors++; if (up_if.data.flit_label !== HEADTAIL) begin n_miscompares++; $display("FAIL t1_label got %0d exp HEADTAIL", up_if.data.flit_label); end
        n_vectors++; if (up_if.data.vc_id !== 2'd0) begin n_miscompares++; $display("FAIL t1_vc got %0d exp 0", up_if.data.vc_id); end
        n_vectors++; if (up_if.data.data !== 16'h004A) begin n_miscompares++; $display("FAIL t1_head_data got %h exp 004a", up_if.data.data); end
        n_vectors++; if (pkt_ready_o !== 1'b1) begin n_miscompares++; $display("FAIL t1_ready_back got %b exp 1", pkt_ready_o); end
        tick();
        n_vectors++; if (up_if.is_valid !== 1'b0) begin n_miscompares++; $display("FAIL t1_valid_drop got %b exp 0", up_if.is_valid); end
    endtask

    // len=4, dest(3,1): HEAD(0x00DA), BODY A, BODY B, TAIL C back to back on VC0.
    task automatic test_multi_flit();
        logic [15:0]  vals [3];
        flit_label_t  labs [3];
        vals = '{16'h000A, 16'h000B, 16'h000C};
        labs = '{BODY, BODY, TAIL};
        send_desc(2'd3, 2'd1, 4'd4);
        tick();
        n_vectors++; if (up_if.is_valid !== 1'b1 || up_if.data.flit_label !== HEAD || up_if.data.vc_id !== 2'd0 || up_if.data.data !== 16'h00DA) begin
            n_miscompares++; $display("FAIL t2_head got v=%b l=%0d vc=%0d d=%h exp v=1 l=HEAD vc=0 d=00da", up_if.is_valid, up_if.data.flit_label, up_if.data.vc_id, up_if.data.data);
        end
        for (int i = 0; i < 3; i++) begin
            pld_valid_i = 1'b1;
            pld_data_i  = vals[i];
            #1;
            n_vectors++; if (pld_ready_o !== 1'b1) begin n_miscompares++; $display("FAIL t2_pld_ready[%0d] got %b exp 1", i, pld_ready_o); end
            tick();
            n_vectors++; if (up_if.is_valid !== 1'b1 || up_if.data.flit_label !== labs[i] || up_if.data.vc_id !== 2'd0 || up_if.data.data !== vals[i]) begin
                n_miscompares++; $display("FAIL t2_flit[%0d] got v=%b l=%0d vc=%0d d=%h exp v=1 l=%0d vc=0 d=%h", i, up_if.is_valid, up_if.data.flit_label, up_if.data.vc_id, up_if.data.data, labs[i], vals[i]);
            end
        end
        pld_valid_i = 1'b0;
        tick();
        n_vectors++; if (up_if.is_valid !== 1'b0) begin n_miscompares++; $display("FAIL t2_after_tail got %b exp 0", up_if.is_valid); end
        n_vectors++; if (dbg_state_o !== IDLE) begin n_miscompares++; $display("FAIL t2_state got %0d exp IDLE", dbg_state_o); end
    endtask

    // Wait in ALLOC (VC0 free but off), then VC2 frees; stall VC2 for 3 cycles.
    task automatic test_alloc_stall();
        up_if.is_allocatable = 4'b0001;
        up_if.is_on_off      = 4'b1110;
        send_desc(2'd0, 2'd3, 4'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vectors++; if (up_if.is_valid !== 1'b0 || dbg_state_o !== ALLOC || pld_ready_o !== 1'b0) begin
                n_miscompares++; $display("FAIL t3_wait[%0d] got v=%b st=%0d pr=%b exp v=0 st=ALLOC pr=0", i, up_if.is_valid, dbg_state_o, pld_ready_o);
            end
        end
        up_if.is_allocatable = 4'b0100;
        tick();
        n_vectors++; if (up_if.is_valid !== 1'b1 || up_if.data.flit_label !== HEAD || up_if.data.vc_id !== 2'd2 || up_if.data.data !== 16'h003A) begin
            n_miscompares++; $display("FAIL t3_head got v=%b l=%0d vc=%0d d=%h exp v=1 l=HEAD vc=2 d=003a", up_if.is_valid, up_if.data.flit_label, up_if.data.vc_id, up_if.data.data);
        end
        pld_valid_i = 1'b1;
        pld_data_i  = 16'h0011;
        tick();
        n_vectors++; if (up_if.is_valid !== 1'b1 || up_if.data.flit_label !== BODY || up_if.data.vc_id !== 2'd2 || up_if.data.data !== 16'h0011) begin
            n_miscompares++; $display("FAIL t3_body got v=%b l=%0d vc=%0d d=%h exp v=1 l=BODY vc=2 d=0011", up_if.is_valid, up_if.data.flit_label, up_if.data.vc_id, up_if.data.data);
        end
        pld_data_i      = 16'h0022;
        up_if.is_on_off = 4'b1010;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_vectors++; if (pld_ready_o !== 1'b0) begin n_miscompares++; $display("FAIL t3_stall_ready[%0d] got %b exp 0", i, pld_ready_o); end
            tick();
            n_vectors++; if (up_if.is_valid !== 1'b0) begin n_miscompares++; $display("FAIL t3_stall_valid[%0d] got %b exp 0", i, up_if.is_valid); end
        end
        up_if.is_on_off = 4'b1110;
        tick();
        n_vectors++; if (up_if.is_valid !== 1'b1 || up_if.data.flit_label !== TAIL || up_if.data.vc_id !== 2'd2 || up_if.data.data !== 16'h0022) begin
            n_miscompares++; $display("FAIL t3_tail got v=%b l=%0d vc=%0d d=%h exp v=1 l=TAIL vc=2 d=0022", up_if.is_valid, up_if.data.flit_label, up_if.data.vc_id, up_if.data.data);
        end
        pld_valid_i = 1'b0;
        up_if.is_allocatable = 4'b1111;
        up_if.is_on_off      = 4'b1111;
        tick();
        n_vectors++; if (up_if.is_valid !== 1'b0 || dbg_state_o !== IDLE) begin n_miscompares++; $display("FAIL t3_end got v=%b st=%0d exp v=0 st=IDLE", up_if.is_valid, dbg_state_o); end
    endtask

    // len=0 and len=MAX+1 are rejected with one error pulse each.
    task automatic test_bad_len();
        logic [LEN_W-1:0] bad [2];
        bad = '{4'd0, 4'd9};
        for (int i = 0; i < 2; i++) begin
            send_desc(2'd1, 2'd1, bad[i]);
            n_vectors++; if (error_o !== 1'b1 || up_if.is_valid !== 1'b0 || dbg_state_o !== IDLE) begin
                n_miscompares++; $display("FAIL t4_err[%0d] got e=%b v=%b st=%0d exp e=1 v=0 st=IDLE", i, error_o, up_if.is_valid, dbg_state_o);
            end
            tick();
            n_vectors++; if (error_o !== 1'b0 || up_if.is_valid !== 1'b0 || dbg_state_o !== IDLE) begin
                n_miscompares++; $display("FAIL t4_after[%0d] got e=%b v=%b st=%0d exp e=0 v=0 st=IDLE", i, error_o, up_if.is_valid, dbg_state_o);
            end
        end
    endtask

    // HEAD/BODY/TAIL on vc1, HEADTAIL on vc0.
    task automatic test_eject();
        flit_t       fl   [4];
        logic [3:0]  hl   [4];
        logic [15:0] cnt  [4];
        fl  = '{'{HEAD, 2'd1, 16'h1111}, '{BODY, 2'd1, 16'h2222}, '{TAIL, 2'd1, 16'h3333}, '{HEADTAIL, 2'd0, 16'h4444}};
        hl  = '{4'b1100, 4'b1000, 4'b1010, 4'b1110};
        cnt = '{16'd0, 16'd0, 16'd1, 16'd2};
        for (int i = 0; i < 4; i++) begin
            down_if.is_valid = 1'b1;
            down_if.data     = fl[i];
            tick();
            n_vectors++; if ({rx_valid_o, rx_head_o, rx_last_o, error_o} !== hl[i] || rx_data_o !== fl[i].data || rx_pkt_cnt_o !== cnt[i]) begin
                n_miscompares++; $display("FAIL t5_rx[%0d] got vhle=%b d=%h c=%0d exp vhle=%b d=%h c=%0d", i, {rx_valid_o, rx_head_o, rx_last_o, error_o}, rx_data_o, rx_pkt_cnt_o, hl[i], fl[i].data, cnt[i]);
            end
        end
        down_if.is_valid = 1'b0;
        tick();
        n_vectors++; if (rx_valid_o !== 1'b0 || error_o !== 1'b0) begin n_miscompares++; $display("FAIL t5_idle got v=%b e=%b exp v=0 e=0", rx_valid_o, error_o); end
    endtask

    task automatic test_eject_error();
        down_if.is_valid = 1'b1;
        down_if.data     = '{TAIL, 2'd3, 16'h5555};
        tick();
        down_if.is_valid = 1'b0;
        n_vectors++; if (rx_valid_o !== 1'b1 || error_o !== 1'b1 || rx_last_o !== 1'b1 || rx_data_o !== 16'h5555) begin
            n_miscompares++; $display("FAIL t6_err got v=%b e=%b l=%b d=%h exp v=1 e=1 l=1 d=5555", rx_valid_o, error_o, rx_last_o, rx_data_o);
        end
        n_vectors++; if (rx_pkt_cnt_o !== 16'd3) begin n_miscompares++; $display("FAIL t6_cnt got %0d exp 3", rx_pkt_cnt_o); end
        tick();
        n_vectors++; if (error_o !== 1'b0) begin n_miscompares++; $display("FAIL t6_err_pulse got %b exp 0", error_o); end
    endtask

    // Counter is at 3: 65532 HEADTAILs take it to 0xFFFF, then one packet wraps it.
    task automatic test_counter_wrap();
        down_if.is_valid = 1'b1;
        down_if.data     = '{HEADTAIL, 2'd0, 16'h0000};
        repeat (65532) tick();
        down_if.is_valid = 1'b0;
        n_vectors++; if (rx_pkt_cnt_o !== 16'hFFFF) begin n_miscompares++; $display("FAIL t7_preload got %h exp ffff", rx_pkt_cnt_o); end
        down_if.is_valid = 1'b1;
        down_if.data     = '{HEAD, 2'd1, 16'h00AA};
        tick();
        down_if.data     = '{TAIL, 2'd1, 16'h00BB};
        tick();
        down_if.is_valid = 1'b0;
        n_vectors++; if (rx_pkt_cnt_o !== 16'h0000 || error_o !== 1'b0 || rx_last_o !== 1'b1) begin
            n_miscompares++; $display("FAIL t7_wrap got c=%h e=%b l=%b exp c=0000 e=0 l=1", rx_pkt_cnt_o, error_o, rx_last_o);
        end
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        rst                  = 1'b1;
        pkt_valid_i          = 1'b0;
        pkt_x_dest_i         = '0;
        pkt_y_dest_i         = '0;
        pkt_len_i            = '0;
        pld_valid_i          = 1'b0;
        pld_data_i           = '0;
        up_if.is_on_off      = '1;
        up_if.is_allocatable = '1;
        down_if.is_valid     = 1'b0;
        down_if.data         = '0;

        test_reset();
        test_single_flit();
        test_multi_flit();
        test_alloc_stall();
        test_bad_len();
        test_eject();
        test_eject_error();
        test_counter_wrap();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
